gnrc_slice_chain: RTL and testbench
===================================

GNRC_SLICE_CHAIN -- requirements
Module: gnrc_slice_chain

Interface
REQ-001 Parameter DW, default 32: payload width in bits, legal range 1 or more.
REQ-002 Parameter DEPTH, default 2: number of cascaded stages, legal range 1..16.
REQ-003 Parameter FORWARD_Q, default 1: when 1, valid/data are registered in each stage.
REQ-004 Parameter BACKWARD_Q, default 1: when 1, ready is registered in each stage using a skid entry.
REQ-005 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-007 flush_i  input  1  synchronous discard of all held entries.
REQ-008 valid_i  input  1  upstream valid.
REQ-009 data_i  input  DW  upstream payload.
REQ-010 ready_o  output  1  upstream ready.
REQ-011 valid_o  output  1  downstream valid.
REQ-012 data_o  output  DW  downstream payload.
REQ-013 ready_i  input  1  downstream ready.
REQ-014 occ_o  output  $clog2(2*DEPTH+1)  count of valid entries held in the chain.

Function
REQ-015 A transfer on either side occurs in a cycle where valid and ready are both high at the rising edge.
REQ-016 Per-stage capacity is 2 when FORWARD_Q=1 and BACKWARD_Q=1, 1 when exactly one is 1, and 0 when both are 0.
REQ-017 With both flags 0, the chain is combinational: valid_o=valid_i, data_o=data_i, ready_o=ready_i, occ_o=0, and DEPTH is ignored.
REQ-018 With FORWARD_Q=1, the latency from input transfer to valid_o on an empty chain is DEPTH cycles.
REQ-019 With FORWARD_Q=0 and BACKWARD_Q=1, an empty chain has 0-cycle latency, and data is held in skid entries only while stalled.
REQ-020 With BACKWARD_Q=1, ready_o is a register output with no combinational path from ready_i.
REQ-021 Sustained throughput is 1 transfer per cycle in every mode while ready_i=1.
REQ-022 Order is preserved; data is never duplicated or dropped except by flush_i or reset.
REQ-023 Once valid_o is high, valid_o and data_o are held stable until ready_i is high.
REQ-024 While flush_i=1: ready_o=0, valid_o=0 (combinational gating), no input is accepted, and all stage valids clear at the edge.
REQ-025 The first cycle after flush_i falls: the chain is empty, ready_o=1, and occ_o=0.
REQ-026 When flush_i coincides with valid_i&ready_i high, flush has priority and the beat is lost.
REQ-027 When the chain is full (occ_o equals capacity*DEPTH), ready_o=0 in the following cycle, unless an output transfer frees space in that cycle.
REQ-028 occ_o is updated each edge as +1 on input transfer, -1 on output transfer, and unchanged when both occur; it saturates at neither bound.

Reset
REQ-029 While rst_ni=0: all stage valids=0, valid_o=0, ready_o=1 (0 when both flags 0 and ready_i=0), occ_o=0, and data registers are don't-care (not reset).
REQ-030 Reset applied mid-transfer discards all entries immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro GNRC_SLICE_CHAIN_STAT_EN defined: the occupancy counter is instantiated and occ_o follows REQ-028.
REQ-032 Macro GNRC_SLICE_CHAIN_STAT_EN undefined: the counter is removed, occ_o is tied to 0, and datapath behaviour is identical.

Structure
REQ-033 Package gnrc_pkg holds the function gnrc_slice_cap(fq,bq) returning per-stage capacity and the localparam rule for occ_o width.
REQ-034 Each stage is an instance of the existing gnrc_slice (DW, FORWARD_Q, BACKWARD_Q) in a generate loop; flush_i fans out to all stages.
REQ-035 gnrc_slice_chain contains only the instance chain, flush gating, and the optional counter.

Verification
REQ-036 DW=16, DEPTH=3, flags 1/1, ready_i=1, data_i 0..9 pushed back-to-back -> data_o 0..9 on 10 consecutive cycles, first beat 3 cycles after its input.
REQ-037 Same config, ready_i=0, valid_i=1 held -> exactly 6 beats accepted, ready_o=0 from the cycle after the 6th, occ_o=6; then ready_i=1 -> 0..5 drained in order.
REQ-038 Full chain, flush_i high for 2 cycles -> valid_o=0 and ready_o=0 during flush; occ_o=0 and ready_o=1 the cycle after; the next push of value 0x00AA emerges first.
REQ-039 Flags 0/1, DEPTH=2, empty chain -> data_i=5 appears on data_o in the same cycle; ready_i toggled 1010... -> no loss, ready_o never depends on same-cycle ready_i.
REQ-040 rst_ni pulled low between edges with 4 entries held -> valid_o=0 and occ_o=0 immediately; after release, push 7 -> output 7 only.
REQ-041 Build without GNRC_SLICE_CHAIN_STAT_EN, rerun REQ-036 -> identical data trace, occ_o constantly 0.

Source files
------------

// File: rtl/gnrc_pkg.sv
// gnrc_pkg: shared helpers for the gnrc valid/ready slice family.
// Per-stage capacity rule and the occupancy counter width rule.
package gnrc_pkg;

  localparam int GNRC_MAX_DEPTH = 16;

  function automatic int gnrc_slice_cap(bit fq, bit bq);
    return int'(fq) + int'(bq);
  endfunction

  function automatic int gnrc_occ_w(int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/gnrc_slice.sv
// gnrc_slice: one valid/ready register slice with optional forward
// register and optional registered-ready skid entry.
module gnrc_slice #(
  parameter int DW         = 32,
  parameter int FORWARD_Q  = 1,
  parameter int BACKWARD_Q = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i
);

  if (FORWARD_Q != 0 && BACKWARD_Q != 0) begin : g_full
    logic          vq;
    logic          sv;
    logic [DW-1:0] dq;
    logic [DW-1:0] sd;
    logic          out_ld;
    logic          in_fire;

    assign in_fire = valid_i & ~sv;
    assign out_ld  = ~vq | ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vq <= 1'b0;
        sv <= 1'b0;
      end else if (flush_i) begin
        vq <= 1'b0;
        sv <= 1'b0;
      end else if (out_ld) begin
        // skid drains first; input is blocked while it is full
        vq <= sv | valid_i;
        sv <= 1'b0;
      end else if (in_fire) begin
        sv <= 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (out_ld)
        dq <= sv ? sd : data_i;
      if (!out_ld && in_fire)
        sd <= data_i;
    end

    assign ready_o = ~sv;
    assign valid_o = vq;
    assign data_o  = dq;
  end else if (FORWARD_Q != 0) begin : g_fwd
    logic          vq;
    logic [DW-1:0] dq;

    assign ready_o = ~vq | ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
        vq <= 1'b0;
      else if (flush_i)
        vq <= 1'b0;
      else if (ready_o)
        vq <= valid_i;
    end

    always_ff @(posedge clk_i) begin
      if (ready_o && valid_i)
        dq <= data_i;
    end

    assign valid_o = vq;
    assign data_o  = dq;
  end else if (BACKWARD_Q != 0) begin : g_bwd
    logic          sv;
    logic [DW-1:0] sd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
        sv <= 1'b0;
      else if (flush_i)
        sv <= 1'b0;
      else if (sv) begin
        if (ready_i)
          sv <= 1'b0;
      end else if (valid_i && !ready_i)
        sv <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
      if (!sv && valid_i && !ready_i)
        sd <= data_i;
    end

    assign ready_o = ~sv;
    assign valid_o = sv | valid_i;
    assign data_o  = sv ? sd : data_i;
  end else begin : g_pass
    assign ready_o = ready_i;
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end

endmodule

// File: rtl/gnrc_slice_chain.sv
// gnrc_slice_chain: DEPTH cascaded gnrc_slice stages with flush gating.
// Define GNRC_SLICE_CHAIN_STAT_EN to build the occupancy counter.
module gnrc_slice_chain
  import gnrc_pkg::*;
#(
  parameter int DW         = 32,
  parameter int DEPTH      = 2,
  parameter int FORWARD_Q  = 1,
  parameter int BACKWARD_Q = 1,
  localparam int OW        = gnrc_occ_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i,
  output logic [OW-1:0] occ_o
);

  logic [DEPTH:0]         v;
  logic [DEPTH:0]         r;
  logic [DEPTH:0][DW-1:0] d;

  assign v[0]     = valid_i & ~flush_i;
  assign d[0]     = data_i;
  assign r[DEPTH] = ready_i & ~flush_i;
  assign ready_o  = r[0] & ~flush_i;
  assign valid_o  = v[DEPTH] & ~flush_i;
  assign data_o   = d[DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    gnrc_slice #(
      .DW        (DW),
      .FORWARD_Q (FORWARD_Q),
      .BACKWARD_Q(BACKWARD_Q)
    ) u_slice (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush_i(flush_i),
      .valid_i(v[i]),
      .data_i (d[i]),
      .ready_o(r[i]),
      .valid_o(v[i+1]),
      .data_o (d[i+1]),
      .ready_i(r[i+1])
    );
  end

`ifdef GNRC_SLICE_CHAIN_STAT_EN
  localparam int CAP = gnrc_slice_cap(FORWARD_Q != 0, BACKWARD_Q != 0);

  logic          in_f;
  logic          out_f;
  logic [OW-1:0] occ_q;

  assign in_f  = valid_i & ready_o;
  assign out_f = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      occ_q <= '0;
    else if (flush_i)
      occ_q <= '0;
    else if (in_f && !out_f)
      occ_q <= occ_q + OW'(1);
    else if (out_f && !in_f)
      occ_q <= occ_q - OW'(1);
  end

  // a fully combinational chain never holds anything
  assign occ_o = (CAP == 0) ? '0 : occ_q;
`else
  assign occ_o = '0;
`endif

endmodule

// File: tb/tb_gnrc_slice_chain.sv
// tb_gnrc_slice_chain: directed bench with scoreboards for a 1/1 chain
// (DW=16, DEPTH=3) and a 0/1 skid-only chain (DEPTH=2).
module tb_gnrc_slice_chain;

`ifdef GNRC_SLICE_CHAIN_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        vi, ri, ro, vo;
  logic [15:0] di, dout;
  logic [2:0]  occ;

  logic        b_fl;
  logic        b_vi, b_ri, b_ro, b_vo;
  logic [15:0] b_di, b_do;
  logic [2:0]  b_occ;

  gnrc_slice_chain #(
    .DW(16), .DEPTH(3), .FORWARD_Q(1), .BACKWARD_Q(1)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .valid_i(vi), .data_i(di), .ready_o(ro),
    .valid_o(vo), .data_o(dout), .ready_i(ri),
    .occ_o(occ)
  );

  gnrc_slice_chain #(
    .DW(16), .DEPTH(2), .FORWARD_Q(0), .BACKWARD_Q(1)
  ) u_sk (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_fl),
    .valid_i(b_vi), .data_i(b_di), .ready_o(b_ro),
    .valid_o(b_vo), .data_o(b_do), .ready_i(b_ri),
    .occ_o(b_occ)
  );

  typedef struct {
    logic [15:0] d;
    int          c;
  } ent_t;

  ent_t        qa[$];
  logic [15:0] qb[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out_a  = 0;
  int n_out_b  = 0;
  int exp_lat  = -1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  ent_t ea;
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (vi && ro)
        qa.push_back('{di, cyc});
      if (vo && ri) begin
        n_out_a++;
        if (qa.size() == 0)
          check("a_spurious", 1, 0);
        else begin
          ea = qa.pop_front();
          check("a_data", 32'(dout), 32'(ea.d));
          if (exp_lat >= 0)
            check("a_lat", cyc - ea.c, exp_lat);
        end
      end
    end
  end

  logic [15:0] eb;
  always @(negedge clk) begin
    if (rst_n && !b_fl) begin
      if (b_vi && b_ro)
        qb.push_back(b_di);
      if (b_vo && b_ri) begin
        n_out_b++;
        if (qb.size() == 0)
          check("b_spurious", 1, 0);
        else begin
          eb = qb.pop_front();
          check("b_data", 32'(b_do), 32'(eb));
        end
      end
    end
  end

  task automatic drain_a(int lim);
    int k = 0;
    while (qa.size() != 0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    check("a_drain", qa.size(), 0);
  endtask

  task automatic drain_b(int lim);
    int k = 0;
    while (qb.size() != 0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    check("b_drain", qb.size(), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    logic r0;
    int   na;
    int   k;
    int   val;

    rst_n = 1'b0;
    flush = 1'b0;
    vi = 1'b0; ri = 1'b0; di = '0;
    b_fl = 1'b0;
    b_vi = 1'b0; b_ri = 1'b0; b_di = '0;
    #1;
    check("rst_vo", vo, 0);
    check("rst_ro", ro, 1);
    check("rst_occ", occ, 0);
    check("rst_b_ro", b_ro, 1);
    step();
    step();
    rst_n = 1'b1;

    // back-to-back stream, constant 3-cycle latency
    ri = 1'b1;
    exp_lat = 3;
    for (int i = 0; i < 10; i++) begin
      step();
      vi = 1'b1;
      di = 16'(i);
    end
    step();
    vi = 1'b0;
    drain_a(20);
    exp_lat = -1;
    check("t1_nout", n_out_a, 10);
    step();
    check("t1_occ", occ, 0);

    // fill against a stalled sink
    ri = 1'b0;
    vi = 1'b1;
    di = 16'd0;
    na = n_out_a;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc = ro;
      check("t2_acc", acc, i < 6);
      step();
      if (acc) di = di + 16'd1;
    end
    check("t2_ro", ro, 0);
    check("t2_vo", vo, 1);
    check("t2_occ", occ, STAT ? 6 : 0);
    vi = 1'b0;
    ri = 1'b1;
    drain_a(20);
    check("t2_nout", n_out_a - na, 6);

    // refill, then flush for two cycles
    ri = 1'b0;
    vi = 1'b1;
    di = 16'h0010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = ro;
      step();
      if (acc) di = di + 16'd1;
    end
    flush = 1'b1;
    di = 16'h0055;
    qa.delete();
    repeat (2) begin
      @(negedge clk);
      check("fl_vo", vo, 0);
      check("fl_ro", ro, 0);
      step();
    end
    flush = 1'b0;
    vi = 1'b0;
    #1;
    check("fl_occ", occ, 0);
    check("fl_ro_after", ro, 1);
    check("fl_vo_after", vo, 0);
    na = n_out_a;
    ri = 1'b1;
    vi = 1'b1;
    di = 16'h00AA;
    step();
    vi = 1'b0;
    drain_a(20);
    check("fl_nout", n_out_a - na, 1);

    // asynchronous reset with 4 entries held
    ri = 1'b0;
    vi = 1'b1;
    di = 16'h0020;
    k = 0;
    na = 0;
    while (na < 4 && k < 20) begin
      @(negedge clk);
      acc = ro;
      step();
      if (acc) begin
        na++;
        di = di + 16'd1;
      end
      k++;
    end
    vi = 1'b0;
    check("ar_cnt", na, 4);
    check("ar_vo_pre", vo, 1);
    check("ar_occ_pre", occ, STAT ? 4 : 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_vo", vo, 0);
    check("ar_occ", occ, 0);
    check("ar_ro", ro, 1);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    na = n_out_a;
    ri = 1'b1;
    vi = 1'b1;
    di = 16'd7;
    step();
    vi = 1'b0;
    drain_a(20);
    repeat (4) step();
    check("ar_nout", n_out_a - na, 1);

    // skid-only chain: zero latency, ready_o registered
    b_ri = 1'b1;
    b_vi = 1'b1;
    b_di = 16'd5;
    #1;
    check("b_vo_comb", b_vo, 1);
    check("b_do_comb", b_do, 5);
    step();
    b_vi = 1'b0;
    val = 0;
    k = 0;
    while (val < 16 && k < 60) begin
      b_vi = 1'b1;
      b_di = 16'(val);
      b_ri = (k % 2) == 0;
      #1;
      r0 = b_ro;
      b_ri = ~b_ri;
      #1;
      check("b_ro_indep", b_ro, r0);
      b_ri = ~b_ri;
      @(negedge clk);
      acc = b_ro;
      step();
      if (acc) val++;
      k++;
    end
    check("b_sent", val, 16);
    b_vi = 1'b0;
    b_ri = 1'b1;
    drain_b(20);
    step();
    check("b_nout", n_out_b, 17);
    check("b_occ", b_occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
